llr_frame_loader: RTL and testbench



---
 rtl/decoder_pkg.sv | 9 +
 rtl/llr_saturate.sv | 22 ++
 rtl/llr_frame_loader.sv | 95 +++++++++
 tb/tb_llr_frame_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared LDPC decoder types and default dimensions.
// Used by the frame loader and the min-sum decoder core.
package decoder_pkg;
  localparam int N_V_DEFAULT   = 44;
  localparam int LLR_W_DEFAULT = 6;
  localparam int LLR_MAX       = 2 ** (LLR_W_DEFAULT - 1) - 1;

  typedef logic signed [LLR_W_DEFAULT-1:0] llr_t;
endpackage

// File: rtl/llr_saturate.sv
// Symmetric signed clip IN_W -> LLR_W; combinational, zero latency.
// No flow control; the most negative output code is never produced.
module llr_saturate #(
  parameter int IN_W  = 8,
  parameter int LLR_W = 6
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [LLR_W-1:0] dout
);
  localparam int MAXV = 2 ** (LLR_W - 1) - 1;
  localparam logic signed [IN_W-1:0] POS_LIM = IN_W'(MAXV);
  localparam logic signed [IN_W-1:0] NEG_LIM = IN_W'(-MAXV);

  always_comb begin
    dout = din[LLR_W-1:0];
    if (din > POS_LIM) begin
      dout = LLR_W'(MAXV);
    end else if (din < NEG_LIM) begin
      dout = LLR_W'(-MAXV);
    end
  end
endmodule

// File: rtl/llr_frame_loader.sv
// Saturates streamed LLRs into double-buffered N_V-sample frames; frame_valid one cycle after final accept.
// in_ready drops only while the bank being filled is still held by the decoder; no frame_ready->in_ready path.
module llr_frame_loader
  import decoder_pkg::*;
#(
  parameter int N_V   = N_V_DEFAULT,
  parameter int IN_W  = 8,
  parameter int LLR_W = LLR_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_llr,
  input  logic                   in_last,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [N_V*LLR_W-1:0]   frame_llr,
  output logic                   len_err
);
  localparam int IDX_W = (N_V > 1) ? $clog2(N_V) : 1;

  logic signed [LLR_W-1:0] bank_q [2][N_V];
  logic [1:0]              full_q;
  logic                    wr_bank_q;
  logic                    rd_bank_q;
  logic [IDX_W-1:0]        wr_idx_q;
  logic                    len_err_q;
  logic signed [LLR_W-1:0] sat_llr;
  logic                    accept;
  logic                    release_frame;
  logic                    at_last;

  llr_saturate #(
    .IN_W  (IN_W),
    .LLR_W (LLR_W)
  ) u_sat (
    .din  (in_llr),
    .dout (sat_llr)
  );

  assign in_ready      = !rst && !full_q[wr_bank_q];
  assign frame_valid   = full_q[rd_bank_q];
  assign accept        = in_valid && in_ready;
  assign release_frame = frame_valid && frame_ready;
  assign at_last       = (wr_idx_q == IDX_W'(N_V - 1));
  assign len_err       = len_err_q;

  // An early in_last aborts the frame, so its sample is not stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '{default: '0};
    end else if (accept && (at_last || !in_last)) begin
      bank_q[wr_bank_q][wr_idx_q] <= sat_llr;
    end
  end

  // Fill and release never hit the same bank: the writer stalls on a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (accept) begin
        if (at_last) begin
          full_q[wr_bank_q] <= 1'b1;
          wr_bank_q         <= ~wr_bank_q;
          wr_idx_q          <= '0;
          if (!in_last) begin
            len_err_q <= 1'b1;
          end
        end else if (in_last) begin
          wr_idx_q  <= '0;
          len_err_q <= 1'b1;
        end else begin
          wr_idx_q <= wr_idx_q + IDX_W'(1);
        end
      end
      if (release_frame) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
      end
    end
  end

  always_comb begin
    frame_llr = '0;
    for (int i = 0; i < N_V; i++) begin
      frame_llr[i*LLR_W +: LLR_W] = bank_q[rd_bank_q][i];
    end
  end
endmodule

// File: tb/tb_llr_frame_loader.sv
// Directed bench for llr_frame_loader: saturation, framing, back-pressure, full rate, length errors, reset.
module tb_llr_frame_loader;
  localparam int N_V   = 44;
  localparam int IN_W  = 8;
  localparam int LLR_W = 6;
  localparam int FW    = N_V * LLR_W;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_llr;
  logic            in_last;
  logic            frame_valid;
  logic            frame_ready;
  logic [FW-1:0]   frame_llr;
  logic            len_err;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  bit mon_en = 1'b0;
  logic [FW-1:0] hs_q[$];

  llr_frame_loader #(.N_V(N_V), .IN_W(IN_W), .LLR_W(LLR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_llr      (in_llr),
    .in_last     (in_last),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_llr   (frame_llr),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mon_en && frame_valid && frame_ready) hs_q.push_back(frame_llr);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k = -1: saturation vectors, k = -2: value equals index, else bounded pattern.
  function automatic int val(input int k, input int i);
    if (k == -1) begin
      case (i)
        0: return 100;
        1: return -128;
        2: return -32;
        3: return 31;
        4: return -5;
        default: return 0;
      endcase
    end
    if (k == -2) return i;
    return ((i * 3 + k * 5) % 63) - 31;
  endfunction

  function automatic logic [LLR_W-1:0] sat_m(input int v);
    int c;
    c = v;
    if (c > 31) c = 31;
    if (c < -31) c = -31;
    return LLR_W'(c);
  endfunction

  function automatic logic [FW-1:0] exp_frame(input int k);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < N_V; i++) f[i*LLR_W +: LLR_W] = sat_m(val(k, i));
    return f;
  endfunction

  task automatic send_frame(input int k, input int n, input int last_at);
    int budget;
    bit acc;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_llr   = IN_W'(val(k, i));
      in_last  = (i == last_at);
      budget   = 0;
      acc      = 1'b0;
      while (!acc && budget < 200) begin
        acc = in_ready;
        if (!acc) stalls++;
        @(posedge clk);
        #1;
        budget++;
      end
      if (!acc) begin
        chk("send_timeout", FW'(acc), FW'(1));
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_ready();
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_llr = '0; in_last = 1'b0; frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_low", FW'(in_ready), FW'(0));
    chk("rst_frame_valid", FW'(frame_valid), FW'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", FW'(in_ready), FW'(1));
    chk("post_rst_frame_llr", frame_llr, '0);
    chk("post_rst_len_err", FW'(len_err), FW'(0));

    // Saturation frame
    send_frame(-1, N_V, N_V - 1);
    chk("sat_frame_valid", FW'(frame_valid), FW'(1));
    chk("sat_s0_100", FW'(frame_llr[0*6 +: 6]), FW'(6'h1F));
    chk("sat_s1_m128", FW'(frame_llr[1*6 +: 6]), FW'(6'h21));
    chk("sat_s2_m32", FW'(frame_llr[2*6 +: 6]), FW'(6'h21));
    chk("sat_s3_31", FW'(frame_llr[3*6 +: 6]), FW'(6'h1F));
    chk("sat_s4_m5", FW'(frame_llr[4*6 +: 6]), FW'(6'h3B));
    pulse_ready();
    chk("sat_released", FW'(frame_valid), FW'(0));

    // Single index frame
    send_frame(-2, N_V, N_V - 1);
    chk("single_valid", FW'(frame_valid), FW'(1));
    chk("single_data", frame_llr, exp_frame(-2));
    chk("single_len_err", FW'(len_err), FW'(0));
    chk("single_in_ready", FW'(in_ready), FW'(1));
    pulse_ready();

    // Back-pressure with three frames
    send_frame(1, N_V, N_V - 1);
    send_frame(2, N_V, N_V - 1);
    chk("bp_in_ready_drop", FW'(in_ready), FW'(0));
    chk("bp_head_frame", frame_llr, exp_frame(1));
    in_valid = 1'b1; in_llr = IN_W'(val(3, 0)); in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stalled", FW'(in_ready), FW'(0));
    pulse_ready();
    chk("bp_valid_held", FW'(frame_valid), FW'(1));
    chk("bp_second_frame", frame_llr, exp_frame(2));
    chk("bp_in_ready_rise", FW'(in_ready), FW'(1));
    send_frame(3, N_V, N_V - 1);
    chk("bp_third_blocked", FW'(in_ready), FW'(0));
    chk("bp_still_second", frame_llr, exp_frame(2));
    pulse_ready();
    chk("bp_third_frame", frame_llr, exp_frame(3));
    chk("bp_in_ready_free", FW'(in_ready), FW'(1));
    pulse_ready();
    chk("bp_drained", FW'(frame_valid), FW'(0));

    // Full rate
    stalls = 0;
    hs_q.delete();
    mon_en = 1'b1;
    frame_ready = 1'b1;
    for (int k = 10; k < 20; k++) send_frame(k, N_V, N_V - 1);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    frame_ready = 1'b0;
    chk("fr_stalls", FW'(stalls), FW'(0));
    chk("fr_handshakes", FW'(hs_q.size()), FW'(10));
    for (int k = 0; k < 10; k++) begin
      if (k < hs_q.size()) chk($sformatf("fr_frame%0d", k), hs_q[k], exp_frame(k + 10));
    end
    chk("fr_idle", FW'(frame_valid), FW'(0));

    // Early in_last
    send_frame(30, 20, 19);
    repeat (2) @(posedge clk);
    #1;
    chk("early_no_valid", FW'(frame_valid), FW'(0));
    chk("early_len_err", FW'(len_err), FW'(1));
    send_frame(31, N_V, N_V - 1);
    chk("early_next_valid", FW'(frame_valid), FW'(1));
    chk("early_next_data", frame_llr, exp_frame(31));
    chk("early_len_err_sticky", FW'(len_err), FW'(1));
    pulse_ready();

    // Reset mid-frame with bank 1 full
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_clears_len_err", FW'(len_err), FW'(0));
    send_frame(40, N_V, N_V - 1);
    send_frame(41, N_V, N_V - 1);
    pulse_ready();
    chk("mid_bank1_shown", frame_llr, exp_frame(41));
    send_frame(42, 30, -1);
    chk("mid_partial_not_valid", FW'(frame_valid), FW'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", FW'(frame_valid), FW'(0));
    chk("mid_rst_llr", frame_llr, '0);
    chk("mid_rst_in_ready", FW'(in_ready), FW'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_after_in_ready", FW'(in_ready), FW'(1));
    send_frame(43, N_V, N_V - 1);
    chk("fresh_valid", FW'(frame_valid), FW'(1));
    chk("fresh_data", frame_llr, exp_frame(43));
    chk("fresh_len_err", FW'(len_err), FW'(0));
    pulse_ready();

    // Missing in_last on the final sample
    send_frame(44, N_V, -1);
    chk("nolast_valid", FW'(frame_valid), FW'(1));
    chk("nolast_data", frame_llr, exp_frame(44));
    chk("nolast_len_err", FW'(len_err), FW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
